vmem_scan: RTL and testbench
============================

VMEM_SCAN -- requirements
Module: vmem_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, meaning sys_clk cycles per digit slot (legal range 1..65535).
REQ-002 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-low.
REQ-004 vmem_data  input  64  video memory bytes; byte d = vmem_data[8d+7:8d], d=0..7.
REQ-005 enable  input  1  1 = scan display; 0 = blank display and hold in IDLE.
REQ-006 page  input  1  0 = show low nibble of each byte; 1 = show high nibble.
REQ-007 blank_lz  input  1  1 = blank leading-zero digits.
REQ-008 an  output  8  digit enables, active-low, one-hot or all-ones; an[d] drives digit d.
REQ-009 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 frame_done  output  1  one-cycle pulse at end of each complete 8-digit frame.

Function
REQ-011 The block SHALL have three states: IDLE, LOAD, SCAN.
REQ-012 IDLE: an=8'hFF, seg=8'hFF; enable=1 -> LOAD next cycle.
REQ-013 LOAD (one cycle): capture vmem_data, page, blank_lz into snapshot registers; digit index=0, prescaler=0; -> SCAN.
REQ-014 SCAN: prescaler counts 0..CLK_DIV-1, wraps to 0; tick = prescaler==CLK_DIV-1.
REQ-015 On tick, digit index increments, 7 wraps to 0.
REQ-016 On tick with digit index 7, snapshot registers SHALL reload from the current inputs (tear-free frames).
REQ-017 vmem_data/page/blank_lz changes mid-frame SHALL have no effect until the next snapshot reload.
REQ-018 enable=0 in SCAN or LOAD -> IDLE next cycle; counters cleared; no frame_done.
REQ-019 Displayed nibble for digit d: snapshot byte d [7:4] if page_snap=1, else [3:0].
REQ-020 Hex decode (active-low g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 dp (seg[7]) SHALL be 0 (lit) only on digit 0 while page_snap=1; else 1.
REQ-022 Leading-zero blanking: for d=1..7, digit d blanked (an[d]=1, seg=8'hFF) when blank_lz_snap=1 and displayed nibbles of digits 7..d are all zero; digit 0 never blanked.
REQ-023 an and seg SHALL be registered: they reflect digit index/state of the previous cycle (1-cycle latency).
REQ-024 frame_done SHALL pulse high for exactly one cycle, the cycle after the tick with digit index 7.
REQ-025 CLK_DIV=1 SHALL give a tick every SCAN cycle (digit advances each cycle).
REQ-026 Exactly one an bit low in SCAN except a blanked digit (all ones); never two bits low.

Reset
REQ-027 sys_rst=0 at a rising edge: state=IDLE, prescaler=0, digit index=0, snapshots=0, an=8'hFF, seg=8'hFF, frame_done=0.
REQ-028 Reset asserted mid-frame SHALL take priority over enable and all ticks in that cycle.
REQ-029 After reset release with enable=1: IDLE -> LOAD -> SCAN; an[0] goes low two cycles after the first SCAN cycle begins... precisely, an=8'hFE appears on the cycle after entering SCAN.

Verification (CLK_DIV=4)
REQ-030 Reset, enable=1, page=0, blank_lz=0, vmem_data=64'h0F0E0D0C0B0A0908 -> an cycles FE,FD,...,7F each 4 cycles; seg = 8'h80,8'h90,8'h88,8'h83,8'hC6,8'hA1,8'h86,8'h8E; frame_done pulses once per 32 cycles.
REQ-031 page=1, vmem_data=64'h10000000000000A0 -> digit 0 shows A with dp lit (seg=8'h08); digit 7 shows 1 (seg=8'hF9).
REQ-032 blank_lz=1, page=0, vmem_data=64'h0000000000000305 -> digits 7..2 an bit stays 1 (seg=8'hFF), digit 1 shows 3, digit 0 shows 5; vmem_data=0 -> only digit 0 shows 0.
REQ-033 Change vmem_data while digit index=3 -> digits 4..7 of that frame show old values; new values from next frame.
REQ-034 Drop enable mid-frame -> an=8'hFF, seg=8'hFF within 2 cycles, no frame_done; re-raise -> scan restarts at digit 0; assert sys_rst=0 during SCAN -> all outputs at reset values after that edge.

Source files
------------

// File: rtl/vmem_scan.sv
// Eight-digit multiplexed hex display scanner driven from a 64-bit video memory word.
// Each frame is shown from a snapshot taken at frame start, so a write mid-frame cannot tear it.
module vmem_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] vmem_data,
  input  logic        enable,
  input  logic        page,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

  state_t            state, state_nxt;
  logic [15:0]       presc;
  logic [2:0]        dig;
  logic [63:0]       data_snap;
  logic              page_snap, blz_snap;
  logic [7:0][3:0]   nib;
  logic [7:0]        zero_up;
  logic              tick, blank_cur;
  logic [7:0]        an_nxt, seg_nxt;
  logic              fd_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  for (genvar d = 0; d < 8; d++) begin : g_nib
    assign nib[d] = page_snap ? data_snap[8*d+4 +: 4] : data_snap[8*d +: 4];
  end

  // zero_up[d]: every displayed nibble from digit 7 down to d is zero
  always_comb begin
    logic run;
    run     = 1'b1;
    zero_up = '0;
    for (int d = 7; d >= 0; d--) begin
      run        = run && (nib[d] == 4'h0);
      zero_up[d] = run;
    end
  end

  assign tick      = (state == SCAN) && (presc == PRESC_MAX);
  assign blank_cur = blz_snap && (dig != 3'd0) && zero_up[dig];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = LOAD;
      LOAD:    state_nxt = enable ? SCAN : IDLE;
      SCAN:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (state == SCAN && !blank_cur) begin
      an_nxt  = ~(8'b1 << dig);
      seg_nxt = {~(page_snap && (dig == 3'd0)), hex7(nib[dig])};
    end
    fd_nxt = tick && (dig == 3'd7) && enable;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      presc      <= '0;
      dig        <= '0;
      data_snap  <= '0;
      page_snap  <= 1'b0;
      blz_snap   <= 1'b0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
      case (state)
        LOAD: begin
          presc     <= '0;
          dig       <= '0;
          data_snap <= vmem_data;
          page_snap <= page;
          blz_snap  <= blank_lz;
        end
        SCAN: begin
          if (!enable) begin
            presc <= '0;
            dig   <= '0;
          end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
              dig <= dig + 3'd1;
              // frame boundary: pick up the next frame's contents
              if (dig == 3'd7) begin
                data_snap <= vmem_data;
                page_snap <= page;
                blz_snap  <= blank_lz;
              end
            end
          end
        end
        default: begin
          presc <= '0;
          dig   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_scan.sv
// Directed bench for vmem_scan with CLK_DIV=4: frame contents, snapshot timing, enable and reset.
module tb_vmem_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] vmem_data;
  logic        enable, page, blank_lz;
  logic [7:0]  an, seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] T1_DATA = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] T2_DATA = 64'h10000000000000A0;
  localparam logic [63:0] T3_DATA = 64'h0000000000000305;
  // per-digit expectations, digit 0 in the low byte
  localparam logic [63:0] AN_ALL  = 64'h7FBFDFEFF7FBFDFE;
  localparam logic [63:0] SEG_T1  = 64'h8E86A1C683889080;
  localparam logic [63:0] SEG_T2  = 64'hF9C0C0C0C0C0C008;
  localparam logic [63:0] AN_T3   = 64'hFFFFFFFFFFFFFDFE;
  localparam logic [63:0] SEG_T3  = 64'hFFFFFFFFFFFFB092;
  localparam logic [63:0] AN_T4   = 64'hFFFFFFFFFFFFFFFE;
  localparam logic [63:0] SEG_T4  = 64'hFFFFFFFFFFFFFFC0;

  vmem_scan #(.CLK_DIV(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .vmem_data  (vmem_data),
    .enable     (enable),
    .page       (page),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_fd"}, {7'b0, frame_done}, 8'h00);
  endtask

  // One full frame, 4 samples per digit; new inputs are driven while digit 3 is on,
  // so they must only show up from the following frame.
  task automatic check_frame(input string tag, input logic [63:0] an_e, input logic [63:0] seg_e,
                             input logic [63:0] nd, input logic np, input logic nb);
    for (int i = 0; i < 32; i++) begin
      @(negedge sys_clk);
      chk({tag, "_an"}, an, an_e[8*(i/4) +: 8]);
      chk({tag, "_seg"}, seg, seg_e[8*(i/4) +: 8]);
      chk({tag, "_fd"}, {7'b0, frame_done}, (i == 31) ? 8'h01 : 8'h00);
      if (i == 13) begin
        vmem_data = nd;
        page      = np;
        blank_lz  = nb;
      end
    end
  endtask

  initial begin
    sys_rst = 1'b0; enable = 1'b1; page = 1'b0; blank_lz = 1'b0; vmem_data = T1_DATA;
    repeat (2) @(negedge sys_clk);
    chk_idle("reset");

    sys_rst = 1'b1;
    @(negedge sys_clk); chk_idle("idle");
    @(negedge sys_clk); chk_idle("load");
    check_frame("hex",   AN_ALL, SEG_T1, T2_DATA, 1'b1, 1'b0);
    check_frame("page1", AN_ALL, SEG_T2, T3_DATA, 1'b0, 1'b1);
    check_frame("lz",    AN_T3,  SEG_T3, 64'h0,   1'b0, 1'b1);
    check_frame("lz0",   AN_T4,  SEG_T4, T1_DATA, 1'b0, 1'b0);

    // drop enable while digit 2 is showing
    repeat (10) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk); chk_idle("en_off");
    repeat (40) begin
      @(negedge sys_clk); chk_idle("en_off_hold");
    end
    enable = 1'b1;
    @(negedge sys_clk); chk_idle("re_idle");
    @(negedge sys_clk); chk_idle("re_load");
    check_frame("restart", AN_ALL, SEG_T1, T1_DATA, 1'b0, 1'b0);

    // reset lands on the digit-7 tick edge, with enable still high
    repeat (31) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk); chk_idle("rst_scan");
    sys_rst = 1'b1;
    @(negedge sys_clk); chk_idle("post_idle");
    @(negedge sys_clk); chk_idle("post_load");
    check_frame("post_rst", AN_ALL, SEG_T1, T1_DATA, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
